// File: rtl/ex_stage.sv
// Execute stage: stage register, combinational ALU with forwarding outputs, and an optional
// iterative HI/LO divider built only when EX_DIV_EN is defined.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [7:0] OpOr   = 8'h25;
    localparam logic [7:0] OpAnd  = 8'h24;
    localparam logic [7:0] OpXor  = 8'h26;
    localparam logic [7:0] OpNor  = 8'h27;
    localparam logic [7:0] OpSll  = 8'h7C;
    localparam logic [7:0] OpSrl  = 8'h02;
    localparam logic [7:0] OpSra  = 8'h03;
    localparam logic [7:0] OpAddu = 8'h21;
    localparam logic [7:0] OpSubu = 8'h23;
    localparam logic [7:0] OpSlt  = 8'h2A;
    localparam logic [7:0] OpSltu = 8'h2B;
    localparam logic [7:0] OpMfhi = 8'h10;
    localparam logic [7:0] OpMflo = 8'h12;

    localparam logic [2:0] SelNop   = 3'd0;
    localparam logic [2:0] SelLogic = 3'd1;
    localparam logic [2:0] SelShift = 3'd2;
    localparam logic [2:0] SelMove  = 3'd3;
    localparam logic [2:0] SelArith = 3'd4;

    logic [7:0]  aluop_q;
    logic [2:0]  alusel_q;
    logic [31:0] reg1_q, reg2_q;
    logic [4:0]  wd_q;
    logic        wreg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            aluop_q  <= 8'h00;
            alusel_q <= SelNop;
            reg1_q   <= '0;
            reg2_q   <= '0;
            wd_q     <= '0;
            wreg_q   <= 1'b0;
        end else if (!stall_i) begin
            aluop_q  <= aluop_i;
            alusel_q <= alusel_i;
            reg1_q   <= reg1_i;
            reg2_q   <= reg2_i;
            wd_q     <= wd_i;
            wreg_q   <= wreg_i;
        end
    end

`ifdef EX_DIV_EN
    localparam logic [7:0] OpDiv  = 8'h1A;
    localparam logic [7:0] OpDivu = 8'h1B;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} div_state_e;

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic        qneg_q, qneg_d, rneg_q, rneg_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic        is_div, is_signed, ge;
    logic [32:0] shifted;
    logic [31:0] diff, mag1, mag2;

    always_comb begin
        is_div     = (aluop_q == OpDiv) || (aluop_q == OpDivu);
        is_signed  = (aluop_q == OpDiv);
        mag1       = (is_signed && reg1_q[31]) ? -reg1_q : reg1_q;
        mag2       = (is_signed && reg2_q[31]) ? -reg2_q : reg2_q;
        // Restoring step: shift next dividend bit into the partial remainder and try to subtract.
        shifted    = {rem_q, quo_q[31]};
        ge         = shifted >= {1'b0, dvs_q};
        diff       = shifted[31:0] - dvs_q;

        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        stallreq_o = 1'b0;

        case (state_q)
            StIdle: begin
                if (is_div) begin
                    stallreq_o = 1'b1;
                    if (reg2_q == '0) begin
                        // Divide-by-zero result is staged so DONE writes it like any other.
                        state_d = StDone;
                        rem_d   = reg1_q;
                        quo_d   = '1;
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                    end else begin
                        state_d = StBusy;
                        cnt_d   = '0;
                        rem_d   = '0;
                        quo_d   = mag1;
                        dvs_d   = mag2;
                        qneg_d  = is_signed && (reg1_q[31] ^ reg2_q[31]);
                        rneg_d  = is_signed && reg1_q[31];
                    end
                end
            end
            StBusy: begin
                stallreq_o = is_div;
                rem_d      = ge ? diff : shifted[31:0];
                quo_d      = {quo_q[30:0], ge};
                cnt_d      = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
                hi_d    = rneg_q ? -rem_q : rem_q;
                lo_d    = qneg_q ? -quo_q : quo_q;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;
`else
    assign stallreq_o = 1'b0;
    assign hi_o       = '0;
    assign lo_o       = '0;
`endif

    always_comb begin
        wdata_o = '0;
        case (alusel_q)
            SelNop: wdata_o = '0;
            SelLogic: begin
                case (aluop_q)
                    OpOr:    wdata_o = reg1_q | reg2_q;
                    OpAnd:   wdata_o = reg1_q & reg2_q;
                    OpXor:   wdata_o = reg1_q ^ reg2_q;
                    OpNor:   wdata_o = ~(reg1_q | reg2_q);
                    default: wdata_o = '0;
                endcase
            end
            SelShift: begin
                case (aluop_q)
                    OpSll:   wdata_o = reg2_q << reg1_q[4:0];
                    OpSrl:   wdata_o = reg2_q >> reg1_q[4:0];
                    OpSra:   wdata_o = $unsigned($signed(reg2_q) >>> reg1_q[4:0]);
                    default: wdata_o = '0;
                endcase
            end
            SelMove: begin
                case (aluop_q)
                    OpMfhi:  wdata_o = hi_o;
                    OpMflo:  wdata_o = lo_o;
                    default: wdata_o = '0;
                endcase
            end
            SelArith: begin
                case (aluop_q)
                    OpAddu:  wdata_o = reg1_q + reg2_q;
                    OpSubu:  wdata_o = reg1_q - reg2_q;
                    OpSlt:   wdata_o = {31'b0, $signed(reg1_q) < $signed(reg2_q)};
                    OpSltu:  wdata_o = {31'b0, reg1_q < reg2_q};
                    default: wdata_o = '0;
                endcase
            end
            default: wdata_o = '0;
        endcase
    end

    assign wd_o   = wd_q;
    assign wreg_o = wreg_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage; divider scenarios are selected by EX_DIV_EN to match the RTL build.
module tb_ex_stage;

    localparam logic [7:0] OpOr = 8'h25, OpAnd = 8'h24, OpXor = 8'h26, OpNor = 8'h27;
    localparam logic [7:0] OpSll = 8'h7C, OpSrl = 8'h02, OpSra = 8'h03;
    localparam logic [7:0] OpAddu = 8'h21, OpSubu = 8'h23, OpSlt = 8'h2A, OpSltu = 8'h2B;
    localparam logic [7:0] OpMfhi = 8'h10, OpMflo = 8'h12, OpDiv = 8'h1A, OpDivu = 8'h1B;
    localparam logic [2:0] SelNop = 3'd0, SelLogic = 3'd1, SelShift = 3'd2, SelMove = 3'd3;
    localparam logic [2:0] SelArith = 3'd4;

    logic        clk = 1'b0;
    logic        rst, stall_i;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq_o;
    logic [31:0] hi_o, lo_o;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
    } exp_t;

    typedef struct {
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    exp_t        exp_q[$];
    logic [63:0] hilo_q[$];

    ex_stage dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall_i),
        .aluop_i    (aluop_i),
        .alusel_i   (alusel_i),
        .reg1_i     (reg1_i),
        .reg2_i     (reg2_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .stallreq_o (stallreq_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always #5 clk = ~clk;

    // Drives one instruction at the falling edge and records what EX must show after the next rise.
    task automatic drive(input vec_t v, input logic [4:0] wd, input logic wreg);
        exp_t e;
        @(negedge clk);
        stall_i  = 1'b0;
        aluop_i  = v.op;
        alusel_i = v.sel;
        reg1_i   = v.a;
        reg2_i   = v.b;
        wd_i     = wd;
        wreg_i   = wreg;
        e.wd     = wd;
        e.wreg   = wreg;
        e.wdata  = v.res;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst      = 1'b1;
        stall_i  = 1'b1;
        aluop_i  = OpOr;
        alusel_i = SelLogic;
        reg1_i   = 32'hFFFF_FFFF;
        reg2_i   = 32'h1;
        wd_i     = 5'd7;
        wreg_i   = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({wd_o, wreg_o, wdata_o} !== 38'd0) begin
            errors++;
            $display("FAIL reset_stage: got wd=%0d wreg=%0b wdata=%h, expected all zero",
                     wd_o, wreg_o, wdata_o);
        end
        checks++;
        if ({stallreq_o, hi_o, lo_o} !== 65'd0) begin
            errors++;
            $display("FAIL reset_hilo: got stallreq=%0b hi=%h lo=%h, expected all zero",
                     stallreq_o, hi_o, lo_o);
        end
        @(negedge clk);
        rst      = 1'b0;
        stall_i  = 1'b0;
        aluop_i  = 8'h00;
        alusel_i = SelNop;
        wd_i     = '0;
        wreg_i   = 1'b0;
    endtask

    task automatic test_logic();
        vec_t v[4];
        exp_t e;
        v[0] = '{OpOr,  SelLogic, 32'h0000_1100, 32'h0000_0020, 32'h0000_1120};
        v[1] = '{OpAnd, SelLogic, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        v[2] = '{OpXor, SelLogic, 32'h1234_5678, 32'hFFFF_0000, 32'hEDCB_5678};
        v[3] = '{OpNor, SelLogic, 32'h0000_FFFF, 32'h00FF_0000, 32'hFF00_0000};
        for (int i = 0; i < 4; i++) begin
            drive(v[i], 5'(i + 5), 1'b1);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({wd_o, wreg_o, wdata_o} !== e) begin
                errors++;
                $display("FAIL logic[%0d]: got wd=%0d wreg=%0b wdata=%h, expected wd=%0d wreg=%0b wdata=%h",
                         i, wd_o, wreg_o, wdata_o, e.wd, e.wreg, e.wdata);
            end
        end
    endtask

    task automatic test_shift();
        vec_t v[5];
        exp_t e;
        v[0] = '{OpSll, SelShift, 32'h0000_0004, 32'h0000_0001, 32'h0000_0010};
        v[1] = '{OpSll, SelShift, 32'h0000_0024, 32'h0000_000F, 32'h0000_00F0};
        v[2] = '{OpSrl, SelShift, 32'h0000_0008, 32'h8000_0000, 32'h0080_0000};
        v[3] = '{OpSra, SelShift, 32'h0000_0004, 32'h8000_0000, 32'hF800_0000};
        v[4] = '{OpSra, SelShift, 32'h0000_0001, 32'h4000_0000, 32'h2000_0000};
        for (int i = 0; i < 5; i++) begin
            drive(v[i], 5'd12, 1'b1);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({wd_o, wreg_o, wdata_o} !== e) begin
                errors++;
                $display("FAIL shift[%0d]: got wdata=%h, expected %h", i, wdata_o, e.wdata);
            end
        end
    endtask

    // Issued back to back: each result must appear the cycle right after its edge.
    task automatic test_arith_back_to_back();
        vec_t v[6];
        exp_t e;
        v[0] = '{OpAddu, SelArith, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
        v[1] = '{OpSubu, SelArith, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        v[2] = '{OpSlt,  SelArith, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        v[3] = '{OpSlt,  SelArith, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
        v[4] = '{OpSltu, SelArith, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        v[5] = '{OpSltu, SelArith, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001};
        for (int i = 0; i < 6; i++) begin
            drive(v[i], 5'(20 + i), 1'b1);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({wd_o, wreg_o, wdata_o} !== e) begin
                errors++;
                $display("FAIL arith[%0d]: got wd=%0d wdata=%h, expected wd=%0d wdata=%h",
                         i, wd_o, wdata_o, e.wd, e.wdata);
            end
        end
    endtask

    // Runs before any divide, so HI/LO are still zero in both builds.
    task automatic test_nop_move();
        vec_t v[5];
        exp_t e;
        v[0] = '{OpOr,   SelNop,   32'h0000_00FF, 32'h0000_00FF, 32'h0};
        v[1] = '{8'h55,  SelLogic, 32'h0000_00FF, 32'h0000_00FF, 32'h0};
        v[2] = '{OpSll,  SelArith, 32'h0000_0001, 32'h0000_0001, 32'h0};
        v[3] = '{OpAddu, 3'd6,     32'h0000_0001, 32'h0000_0001, 32'h0};
        v[4] = '{OpMfhi, SelMove,  32'h0000_0001, 32'h0000_0001, 32'h0};
        for (int i = 0; i < 5; i++) begin
            drive(v[i], 5'd3, 1'b1);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({wd_o, wreg_o, wdata_o} !== e) begin
                errors++;
                $display("FAIL nop[%0d]: got wreg=%0b wdata=%h, expected wreg=%0b wdata=%h",
                         i, wreg_o, wdata_o, e.wreg, e.wdata);
            end
        end
    endtask

    task automatic test_stall();
        vec_t v;
        exp_t e;
        v = '{OpOr, SelLogic, 32'h1, 32'h2, 32'h3};
        drive(v, 5'd9, 1'b1);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        @(negedge clk);
        stall_i  = 1'b1;
        aluop_i  = OpAnd;
        reg1_i   = 32'hFFFF_FFFF;
        reg2_i   = 32'h0000_00F0;
        wd_i     = 5'd4;
        wreg_i   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({wd_o, wreg_o, wdata_o} !== e) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got wd=%0d wreg=%0b wdata=%h, expected wd=%0d wreg=%0b wdata=%h",
                         i, wd_o, wreg_o, wdata_o, e.wd, e.wreg, e.wdata);
            end
        end
        @(negedge clk);
        stall_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({wd_o, wreg_o, wdata_o} !== {5'd4, 1'b0, 32'h0000_00F0}) begin
            errors++;
            $display("FAIL stall_release: got wd=%0d wreg=%0b wdata=%h, expected wd=4 wreg=0 wdata=000000f0",
                     wd_o, wreg_o, wdata_o);
        end
    endtask

`ifdef EX_DIV_EN
    // Plays the pipeline controller (stall while stallreq_o), then reads LO and HI back via MFLO/MFHI.
    task automatic test_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                            input int exp_stalls);
        logic [63:0] hl;
        int n;
        @(negedge clk);
        stall_i  = 1'b0;
        aluop_i  = op;
        alusel_i = SelArith;
        reg1_i   = a;
        reg2_i   = b;
        wd_i     = 5'd0;
        wreg_i   = 1'b0;
        hilo_q.push_back({exp_hi, exp_lo});
        @(posedge clk); #1;
        checks++;
        if ({wreg_o, wdata_o} !== 33'd0) begin
            errors++;
            $display("FAIL div_wb %h/%h: got wreg=%0b wdata=%h, expected 0/0", a, b, wreg_o, wdata_o);
        end
        n = 0;
        while (stallreq_o === 1'b1 && n < 100) begin
            n++;
            stall_i = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (n != exp_stalls) begin
            errors++;
            $display("FAIL div_stalls %h/%h: got %0d stall cycles, expected %0d", a, b, n, exp_stalls);
        end
        @(negedge clk);
        stall_i  = 1'b0;
        aluop_i  = OpMflo;
        alusel_i = SelMove;
        wd_i     = 5'd2;
        wreg_i   = 1'b1;
        @(posedge clk); #1;
        hl = hilo_q.pop_front();
        checks++;
        if ({hi_o, lo_o} !== hl) begin
            errors++;
            $display("FAIL div_hilo %h/%h: got hi=%h lo=%h, expected hi=%h lo=%h",
                     a, b, hi_o, lo_o, hl[63:32], hl[31:0]);
        end
        checks++;
        if (wdata_o !== hl[31:0]) begin
            errors++;
            $display("FAIL div_mflo %h/%h: got %h, expected %h", a, b, wdata_o, hl[31:0]);
        end
        @(negedge clk);
        aluop_i = OpMfhi;
        @(posedge clk); #1;
        checks++;
        if (wdata_o !== hl[63:32]) begin
            errors++;
            $display("FAIL div_mfhi %h/%h: got %h, expected %h", a, b, wdata_o, hl[63:32]);
        end
    endtask

    task automatic test_div_reset();
        @(negedge clk);
        stall_i  = 1'b0;
        aluop_i  = OpDiv;
        alusel_i = SelArith;
        reg1_i   = 32'hFFFF_FFF9;
        reg2_i   = 32'h2;
        wreg_i   = 1'b0;
        @(posedge clk); #1;
        stall_i = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({stallreq_o, hi_o, lo_o, wdata_o} !== 97'd0) begin
            errors++;
            $display("FAIL div_reset: got stallreq=%0b hi=%h lo=%h wdata=%h, expected all zero",
                     stallreq_o, hi_o, lo_o, wdata_o);
        end
        @(negedge clk);
        rst     = 1'b0;
        stall_i = 1'b0;
        test_div(OpDivu, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    endtask
`else
    task automatic test_no_div();
        int seen;
        @(negedge clk);
        stall_i  = 1'b0;
        aluop_i  = OpDiv;
        alusel_i = SelArith;
        reg1_i   = 32'd100;
        reg2_i   = 32'd3;
        wd_i     = 5'd0;
        wreg_i   = 1'b0;
        seen     = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (stallreq_o !== 1'b0 || wdata_o !== 32'd0 || hi_o !== 32'd0 || lo_o !== 32'd0)
                seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL no_div: got %0d cycles with stallreq/wdata/hi/lo nonzero, expected 0 (last stallreq=%0b hi=%h lo=%h)",
                     seen, stallreq_o, hi_o, lo_o);
        end
        @(negedge clk);
        aluop_i  = OpMflo;
        alusel_i = SelMove;
        wreg_i   = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (wdata_o !== 32'd0) begin
            errors++;
            $display("FAIL no_div_mflo: got %h, expected 00000000", wdata_o);
        end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        stall_i  = 1'b0;
        aluop_i  = '0;
        alusel_i = '0;
        reg1_i   = '0;
        reg2_i   = '0;
        wd_i     = '0;
        wreg_i   = 1'b0;
        test_reset();
        test_nop_move();
        test_logic();
        test_shift();
        test_arith_back_to_back();
        test_stall();
`ifdef EX_DIV_EN
        test_div(OpDiv,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        test_div(OpDiv,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33);
        test_div(OpDiv,  32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002, 33);
        test_div(OpDivu, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0000, 32'h5555_5555, 33);
        test_div(OpDivu, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1);
        test_div_reset();
`else
        test_no_div();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
